// File: rtl/ccff_loader.sv
// ccff_loader: streams host words LSB-first into a configuration flip-flop chain, with an optional tail-compare verify pass.
// Latency: start -> FETCH on the sampling edge; each word costs one FETCH cycle plus DATA_W SHIFT cycles.
// Backpressure: din_ready is high only in FETCH; a host stall keeps the chain clock gate closed and the counters frozen.
module ccff_loader #(
   parameter int CHAIN_LEN = 48,
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              ccff_head,
   output logic              chain_clk_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  bit_cnt
);

   // Bit index only ever holds 0..DATA_W-1; DATA_W >= 2 keeps this at least 1 bit wide.
   localparam int IDX_W = $clog2(DATA_W);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Terminal values compared against the current (pre-increment) counters, so the
   // exit decision is made on the same edge that shifts the last bit.
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] buf_q,   buf_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              err_q,   err_d;
   logic              vmode_q, vmode_d;
   logic              head_q,  head_d;
   logic              en_q,    en_d;

   // Next-state logic: head/enable are computed one cycle ahead so both leave the block straight from flops.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      vmode_d = vmode_q;
      head_d  = head_q;
      en_d    = en_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // A start in IDLE/DONE wins over any concurrent din_valid; data is only taken in FETCH.
            if (start) begin
               state_d = S_FETCH;
               vmode_d = verify;
               cnt_d   = '0;
               err_d   = 1'b0;
               head_d  = 1'b0;
               en_d    = 1'b0;
            end
         end

         S_FETCH: begin
            if (din_valid) begin
               state_d = S_SHIFT;
               buf_d   = din;
               idx_d   = '0;
               head_d  = din[0];
               en_d    = 1'b1;
            end
         end

         S_SHIFT: begin
            // This edge shifts head_q into the chain.
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q + IDX_W'(1);

            // In a verify pass the tail returns bit k of the previous identical pass
            // exactly while bit k is presented, so any difference is a chain fault.
            if (vmode_q && (ccff_tail != head_q)) begin
               err_d = 1'b1;
            end

            if (cnt_q == CNT_LAST) begin
               // Last chain bit: leftover bits of the final word are dropped.
               state_d = S_DONE;
               head_d  = 1'b0;
               en_d    = 1'b0;
            end else if (idx_q == IDX_LAST) begin
               state_d = S_FETCH;
               head_d  = 1'b0;
               en_d    = 1'b0;
            end else begin
               buf_d  = buf_q >> 1;
               head_d = buf_q[1];
               en_d   = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            head_d  = 1'b0;
            en_d    = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; a reset mid-pass aborts at once.
   always_ff @(posedge prog_clk) begin
      if (!pReset) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         vmode_q <= 1'b0;
         head_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         vmode_q <= vmode_d;
         head_q  <= head_d;
         en_q    <= en_d;
      end
   end

   assign din_ready    = (state_q == S_FETCH);
   assign busy         = (state_q == S_FETCH) || (state_q == S_SHIFT);
   assign done         = (state_q == S_DONE);
   assign err          = err_q;
   assign bit_cnt      = cnt_q;
   assign ccff_head    = head_q;
   assign chain_clk_en = en_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: a 48-bit/8-bit instance and a 13-bit/8-bit instance,
// each feeding a behavioural model of the downstream flip-flop chain.
module tb_ccff_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Instance A: CHAIN_LEN=48, DATA_W=8
   logic        a_rst_n, a_start, a_verify, a_din_valid, a_din_ready;
   logic        a_head, a_en, a_tail, a_busy, a_done, a_err;
   logic [7:0]  a_din;
   logic [15:0] a_bit_cnt;

   // Instance B: CHAIN_LEN=13, DATA_W=8
   logic        b_rst_n, b_start, b_verify, b_din_valid, b_din_ready;
   logic        b_head, b_en, b_tail, b_busy, b_done, b_err;
   logic [7:0]  b_din;
   logic [15:0] b_bit_cnt;

   // Chain models: bit [N-1] is the last flip-flop, driving ccff_tail.
   logic [47:0] chain48 = '0;
   logic [12:0] chain13 = '0;
   assign a_tail = chain48[47];
   assign b_tail = chain13[12];

   // Serial stream captured on enabled edges, index = shift order.
   logic [47:0] stream48;
   logic [12:0] stream13;
   int          nsh48, nsh13;

   logic [7:0]  bytes48 [6];

   ccff_loader #(.CHAIN_LEN(48), .DATA_W(8), .CNT_W(16)) dut_a (
      .prog_clk(clk), .pReset(a_rst_n), .start(a_start), .verify(a_verify),
      .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
      .ccff_head(a_head), .chain_clk_en(a_en), .ccff_tail(a_tail),
      .busy(a_busy), .done(a_done), .err(a_err), .bit_cnt(a_bit_cnt)
   );

   ccff_loader #(.CHAIN_LEN(13), .DATA_W(8), .CNT_W(16)) dut_b (
      .prog_clk(clk), .pReset(b_rst_n), .start(b_start), .verify(b_verify),
      .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
      .ccff_head(b_head), .chain_clk_en(b_en), .ccff_tail(b_tail),
      .busy(b_busy), .done(b_done), .err(b_err), .bit_cnt(b_bit_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample what is presented, let the edge happen, then move the chain models.
   task automatic tick();
      logic h48, e48, h13, e13;
      h48 = a_head; e48 = a_en;
      h13 = b_head; e13 = b_en;
      @(posedge clk);
      #1;
      if (e48 === 1'b1) begin
         chain48 = {chain48[46:0], h48};
         if (nsh48 < 48) stream48[nsh48] = h48;
         nsh48++;
      end
      if (e13 === 1'b1) begin
         chain13 = {chain13[11:0], h13};
         if (nsh13 < 13) stream13[nsh13] = h13;
         nsh13++;
      end
   endtask

   function automatic logic [47:0] rev48(input logic [47:0] s);
      logic [47:0] r;
      for (int k = 0; k < 48; k++) r[47-k] = s[k];
      return r;
   endfunction

   function automatic logic [12:0] rev13(input logic [12:0] s);
      logic [12:0] r;
      for (int k = 0; k < 13; k++) r[12-k] = s[k];
      return r;
   endfunction

   // One pass on instance A with an always-valid host, optionally stalling before a
   // given byte, pulsing start after a given bit, or resetting after a given bit.
   task automatic run48(input logic vmode, input int stall_byte, input int pulse_at,
                        input int abort_at, output int cycles, output int hs,
                        output int first_err);
      int  bi;
      int  stallc;
      logic acc;
      nsh48     = 0;
      stream48  = '0;
      cycles    = 0;
      hs        = 0;
      first_err = -1;
      bi        = 0;
      stallc    = 0;
      a_start     = 1'b1;
      a_verify    = vmode;
      a_din_valid = 1'b1;
      a_din       = bytes48[0];
      tick();
      a_start = 1'b0;
      chk("start_din_ready", 64'(a_din_ready), 64'd1);
      chk("start_busy",      64'(a_busy),      64'd1);
      chk("start_cleared",   64'({a_done, a_err, a_en}), 64'd0);
      chk("start_bit_cnt",   64'(a_bit_cnt),   64'd0);
      while (a_done !== 1'b1 && cycles < 300) begin
         if (abort_at >= 0 && nsh48 == abort_at) begin
            a_rst_n = 1'b0;
            tick();
            a_rst_n = 1'b1;
            break;
         end
         if (a_din_ready === 1'b1 && bi == stall_byte && stallc < 5) begin
            a_din_valid = 1'b0;
            stallc++;
            chk("stall_clk_en",  64'(a_en),      64'd0);
            chk("stall_bit_cnt", 64'(a_bit_cnt), 64'(bi * 8));
         end else begin
            a_din_valid = 1'b1;
         end
         if (a_en === 1'b1 && nsh48 == pulse_at) begin
            a_start  = 1'b1;
            a_verify = ~vmode;
         end else begin
            a_start  = 1'b0;
            a_verify = vmode;
         end
         a_din = (bi < 6) ? bytes48[bi] : 8'h00;
         acc   = a_din_ready && a_din_valid;
         tick();
         cycles++;
         if (acc) begin
            hs++;
            bi++;
         end
         if (a_err === 1'b1 && first_err < 0) first_err = nsh48;
      end
      a_start = 1'b0;
      if (abort_at < 0) chk("pass_timeout", 64'(cycles < 300), 64'd1);
   endtask

   int cyc, hs, ferr, bi13;
   logic acc13;
   logic [47:0] exp_stream;

   initial begin
      a_rst_n = 1'b0; a_start = 1'b0; a_verify = 1'b0; a_din_valid = 1'b0; a_din = '0;
      b_rst_n = 1'b0; b_start = 1'b0; b_verify = 1'b0; b_din_valid = 1'b0; b_din = '0;
      nsh48 = 0; nsh13 = 0; stream48 = '0; stream13 = '0;
      bytes48[0] = 8'h01; bytes48[1] = 8'h23; bytes48[2] = 8'h45;
      bytes48[3] = 8'h67; bytes48[4] = 8'h89; bytes48[5] = 8'hAB;
      exp_stream = 48'hAB8967452301;

      // Reset values
      tick(); tick();
      chk("rst_a_outputs", 64'({a_din_ready, a_head, a_en, a_busy, a_done, a_err}), 64'd0);
      chk("rst_a_bit_cnt", 64'(a_bit_cnt), 64'd0);
      chk("rst_b_outputs", 64'({b_din_ready, b_head, b_en, b_busy, b_done, b_err}), 64'd0);
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      tick();
      chk("idle_a_outputs", 64'({a_din_ready, a_en, a_busy, a_done}), 64'd0);

      // Load pass, 48 bits
      run48(1'b0, -1, -1, -1, cyc, hs, ferr);
      chk("load_cycles",  64'(cyc),   64'd54);
      chk("load_shifts",  64'(nsh48), 64'd48);
      chk("load_hs",      64'(hs),    64'd6);
      chk("load_stream",  64'(stream48), 64'(exp_stream));
      chk("load_bit_cnt", 64'(a_bit_cnt), 64'd48);
      chk("load_status",  64'({a_done, a_busy, a_err, a_en}), 64'b1000);
      chk("load_chain",   64'(chain48), 64'(rev48(exp_stream)));
      tick(); tick();
      chk("done_held",    64'({a_done, a_din_ready}), 64'b10);

      // Verify pass, identical bytes
      run48(1'b1, -1, -1, -1, cyc, hs, ferr);
      chk("verify_cycles", 64'(cyc),  64'd54);
      chk("verify_err",    64'({a_done, a_err}), 64'b10);
      chk("verify_no_err", 64'(ferr + 1), 64'd0);
      chk("verify_chain",  64'(chain48), 64'(rev48(exp_stream)));

      // Verify mismatch: bit 24 differs
      bytes48[3] = 8'h66;
      run48(1'b1, -1, -1, -1, cyc, hs, ferr);
      chk("mis_first_err", 64'(ferr), 64'd25);
      chk("mis_err_done",  64'({a_done, a_err}), 64'b11);
      chk("mis_stream",    64'(stream48), 64'h0000AB8966452301);
      tick(); tick();
      chk("mis_err_sticky", 64'(a_err), 64'd1);
      bytes48[3] = 8'h67;

      // Host stall before byte 2 and a start pulse mid-SHIFT
      run48(1'b0, 2, 30, -1, cyc, hs, ferr);
      chk("stall_cycles",  64'(cyc),   64'd59);
      chk("stall_shifts",  64'(nsh48), 64'd48);
      chk("stall_hs",      64'(hs),    64'd6);
      chk("stall_stream",  64'(stream48), 64'(exp_stream));
      chk("stall_status",  64'({a_done, a_err}), 64'b10);
      chk("stall_bit_cnt", 64'(a_bit_cnt), 64'd48);

      // Reset after 20 bits, then a clean reload
      run48(1'b0, -1, -1, 20, cyc, hs, ferr);
      chk("abort_outputs", 64'({a_din_ready, a_head, a_en, a_busy, a_done, a_err}), 64'd0);
      chk("abort_bit_cnt", 64'(a_bit_cnt), 64'd0);
      tick();
      chk("abort_idle",    64'({a_din_ready, a_busy, a_done}), 64'd0);
      run48(1'b0, -1, -1, -1, cyc, hs, ferr);
      chk("reload_cycles", 64'(cyc), 64'd54);
      chk("reload_stream", 64'(stream48), 64'(exp_stream));
      chk("reload_chain",  64'(chain48), 64'(rev48(exp_stream)));

      // Partial last byte on instance B: 13 bits = 0xFF + bits 0..4 of 0x15
      nsh13 = 0; stream13 = '0; cyc = 0; hs = 0; bi13 = 0;
      b_start = 1'b1; b_din_valid = 1'b1; b_din = 8'hFF;
      tick();
      b_start = 1'b0;
      chk("b_start_ready", 64'(b_din_ready), 64'd1);
      while (b_done !== 1'b1 && cyc < 100) begin
         acc13 = b_din_ready && b_din_valid;
         tick();
         cyc++;
         if (acc13) begin
            hs++;
            bi13++;
            b_din = (bi13 == 1) ? 8'h15 : 8'h00;
         end
      end
      chk("b_timeout", 64'(cyc < 100), 64'd1);
      for (int i = 0; i < 4; i++) begin
         acc13 = b_din_ready && b_din_valid;
         tick();
         if (acc13) hs++;
      end
      chk("b_cycles",  64'(cyc),   64'd15);
      chk("b_shifts",  64'(nsh13), 64'd13);
      chk("b_hs",      64'(hs),    64'd2);
      chk("b_stream",  64'(stream13), 64'h15FF);
      chk("b_bit_cnt", 64'(b_bit_cnt), 64'd13);
      chk("b_chain",   64'(chain13), 64'(rev13(13'h15FF)));
      chk("b_status",  64'({b_done, b_busy, b_en, b_din_ready}), 64'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
